mor1kx_spr_initiator: RTL and testbench

MOR1KX_SPR_INITIATOR -- requirements
Module: mor1kx_spr_initiator

---
 rtl/mor1kx_spr_initiator.sv | 121 ++++++++++++
 tb/tb_mor1kx_spr_initiator.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mor1kx_spr_initiator.sv
// SPR bus initiator: one request at a time, IDLE -> ACCESS -> RESP handshake.
// Optional ACCESS timeout is compiled in with MOR1KX_SPR_TIMEOUT_EN.
module mor1kx_spr_initiator #(
  parameter int          OPTION_SPR_TIMEOUT = 16,
  parameter logic [31:0] OPTION_SPR_GROUPS  = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [15:0] req_addr_i,
  input  logic [31:0] req_dat_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic [31:0] spr_access_o,
  output logic        spr_we_o,
  output logic [15:0] spr_addr_o,
  output logic [31:0] spr_dat_o,
  input  logic [31:0] spr_bus_ack_i,
  input  logic [31:0] spr_bus_dat_i
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] rsp_dat_q, rsp_dat_d;
  logic        rsp_err_q, rsp_err_d;
  logic [4:0]  grp;
  logic        ack;
  logic        timeout;

  assign grp = addr_q[15:11];
  assign ack = spr_bus_ack_i[grp];

`ifdef MOR1KX_SPR_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  assign timeout = (cnt_q == 8'(OPTION_SPR_TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= 8'd0;
    else     cnt_q <= cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE)                  cnt_d = 8'd0;
    else if (state_q == ACCESS && !ack)   cnt_d = cnt_q + 8'd1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= 16'd0;
      dat_q     <= 32'd0;
      rsp_dat_q <= 32'd0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      dat_q     <= dat_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
    end

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    dat_d     = dat_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;
    case (state_q)
      IDLE:
        if (req_valid_i) begin
          we_d   = req_we_i;
          addr_d = req_addr_i;
          dat_d  = req_dat_i;
          if (OPTION_SPR_GROUPS[req_addr_i[15:11]]) begin
            state_d = ACCESS;
          end else begin
            // Absent group: answer with an error without touching the bus.
            state_d   = RESP;
            rsp_dat_d = 32'd0;
            rsp_err_d = 1'b1;
          end
        end
      ACCESS:
        if (ack) begin
          state_d   = RESP;
          rsp_dat_d = we_q ? 32'd0 : spr_bus_dat_i;
          rsp_err_d = 1'b0;
        end else if (timeout) begin
          state_d   = RESP;
          rsp_dat_d = 32'd0;
          rsp_err_d = 1'b1;
        end
      RESP:
        if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // rst gates ready directly so nothing is accepted while reset is held.
  assign req_ready_o  = (state_q == IDLE) && !rst;
  assign rsp_valid_o  = (state_q == RESP);
  assign rsp_dat_o    = rsp_dat_q;
  assign rsp_err_o    = rsp_err_q;
  assign spr_access_o = (state_q == ACCESS) ? (32'd1 << grp) : 32'd0;
  assign spr_we_o     = (state_q == ACCESS) && we_q;
  assign spr_addr_o   = addr_q;
  assign spr_dat_o    = dat_q;
endmodule

// File: tb/tb_mor1kx_spr_initiator.sv
// Directed plus randomized bench for mor1kx_spr_initiator against a
// transaction-level model (group mask, ack delay, response hold).
module tb_mor1kx_spr_initiator;
  localparam logic [31:0] MASK = 32'h7F7F_FFEF;
  localparam int          TMO  = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_i = 1'b0, req_ready_o, req_we_i = 1'b0;
  logic [15:0] req_addr_i = '0;
  logic [31:0] req_dat_i = '0;
  logic        rsp_valid_o, rsp_ready_i = 1'b0, rsp_err_o;
  logic [31:0] rsp_dat_o, spr_access_o, spr_dat_o;
  logic        spr_we_o;
  logic [15:0] spr_addr_o;
  logic [31:0] spr_bus_ack_i = '0, spr_bus_dat_i = '0;

  int vecs = 0, errs = 0;

  mor1kx_spr_initiator #(.OPTION_SPR_TIMEOUT(TMO), .OPTION_SPR_GROUPS(MASK)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_dat_i(req_dat_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
    .rsp_err_o(rsp_err_o),
    .spr_access_o(spr_access_o), .spr_we_o(spr_we_o), .spr_addr_o(spr_addr_o),
    .spr_dat_o(spr_dat_o), .spr_bus_ack_i(spr_bus_ack_i), .spr_bus_dat_i(spr_bus_dat_i)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction, starting and ending in IDLE (#1 after an edge).
  // delay = ACCESS cycles before the ack cycle; hold = cycles rsp_ready_i stays 0.
  task automatic xact(input logic we, input logic [15:0] addr, input logic [31:0] dat,
                      input int delay, input logic [31:0] bdat, input int hold);
    int g;
    logic [31:0] exp_dat;
    logic        exp_err;
    g = int'(addr[15:11]);
    chk("idle_ready", {31'd0, req_ready_o}, 32'd1);
    chk("idle_rspv", {31'd0, rsp_valid_o}, 32'd0);
    req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr; req_dat_i = dat;
    step();
    req_valid_i = 1'b0; req_we_i = $urandom; req_addr_i = 16'($urandom); req_dat_i = $urandom;
    if (MASK[g]) begin
      for (int k = 0; k <= delay; k++) begin
        chk("acc_sel", spr_access_o, 32'd1 << g);
        chk("acc_we", {31'd0, spr_we_o}, {31'd0, we});
        chk("acc_addr", {16'd0, spr_addr_o}, {16'd0, addr});
        chk("acc_dat", spr_dat_o, dat);
        chk("acc_rspv", {31'd0, rsp_valid_o}, 32'd0);
        chk("acc_ready", {31'd0, req_ready_o}, 32'd0);
        // Foreign ack bits are noise; only bit g may complete the access.
        spr_bus_ack_i = $urandom & ~(32'd1 << g);
        if (k == delay) spr_bus_ack_i[g] = 1'b1;
        spr_bus_dat_i = (k == delay) ? bdat : $urandom;
        step();
      end
      spr_bus_ack_i = '0;
      exp_dat = we ? 32'd0 : bdat;
      exp_err = 1'b0;
    end else begin
      exp_dat = 32'd0;
      exp_err = 1'b1;
    end
    for (int h = 0; h <= hold; h++) begin
      chk("rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
      chk("rsp_dat", rsp_dat_o, exp_dat);
      chk("rsp_err", {31'd0, rsp_err_o}, {31'd0, exp_err});
      chk("rsp_noacc", spr_access_o, 32'd0);
      chk("rsp_nowe", {31'd0, spr_we_o}, 32'd0);
      chk("rsp_ready", {31'd0, req_ready_o}, 32'd0);
      req_valid_i = 1'b1;
      rsp_ready_i = (h == hold);
      step();
    end
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b0;
    chk("post_rspv", {31'd0, rsp_valid_o}, 32'd0);
    chk("post_noacc", spr_access_o, 32'd0);
  endtask

  initial begin
    int n;
    logic [15:0] a;
    #2;
    chk("rst_ready", {31'd0, req_ready_o}, 32'd0);
    chk("rst_rspv", {31'd0, rsp_valid_o}, 32'd0);
    chk("rst_dat", rsp_dat_o, 32'd0);
    chk("rst_err", {31'd0, rsp_err_o}, 32'd0);
    chk("rst_acc", spr_access_o, 32'd0);
    chk("rst_addr", {16'd0, spr_addr_o}, 32'd0);
    chk("rst_sdat", spr_dat_o, 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("rel_ready", {31'd0, req_ready_o}, 32'd1);

    // Read group 9, combinational ack.
    xact(1'b0, 16'h4802, 32'h0, 0, 32'hA5A5_0001, 0);
    // Write group 9, ack on third ACCESS cycle.
    xact(1'b1, 16'h4800, 32'h0000_00F0, 2, 32'hDEAD_BEEF, 0);
    // Absent group 4.
    xact(1'b0, 16'h2000, 32'h0, 0, 32'h1234_5678, 0);
    // Response back-pressure with a waiting request.
    xact(1'b0, 16'h0805, 32'h0, 1, 32'hCAFE_F00D, 5);

    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      xact(1'($urandom), a, $urandom, int'($urandom_range(0, 4)), $urandom,
           int'($urandom_range(0, 3)));
    end

    // No ack at all on group 9.
    req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 16'h4810; req_dat_i = 32'h55;
    step();
    req_valid_i = 1'b0;
    n = 0;
`ifdef MOR1KX_SPR_TIMEOUT_EN
    while (spr_access_o != 32'd0 && n < 3 * TMO) begin
      n++;
      step();
    end
    chk("tmo_cycles", n, TMO);
    chk("tmo_rspv", {31'd0, rsp_valid_o}, 32'd1);
    chk("tmo_err", {31'd0, rsp_err_o}, 32'd1);
    chk("tmo_dat", rsp_dat_o, 32'd0);
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    chk("tmo_idle", {31'd0, req_ready_o}, 32'd1);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 16'h4810;
    step();
    req_valid_i = 1'b0;
    step(); step();
`else
    while (n < 1000) begin
      if (rsp_valid_o) break;
      n++;
      step();
    end
    chk("hang_norsp", n, 1000);
`endif
    // Reset in the middle of an ACCESS must drop the strobes immediately.
    chk("pre_rst_acc", spr_access_o, 32'h0000_0200);
    chk("pre_rst_we", {31'd0, spr_we_o}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_acc", spr_access_o, 32'd0);
    chk("arst_we", {31'd0, spr_we_o}, 32'd0);
    chk("arst_ready", {31'd0, req_ready_o}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("arel_ready", {31'd0, req_ready_o}, 32'd1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid_o || spr_access_o != 32'd0) n++;
      step();
    end
    chk("arel_quiet", n, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
